lifo_stack: RTL and testbench

Parameterised register-file LIFO that accepts push, pop and replace requests and always presents its top two entries. It is the responding end of the push/pop/s0/s1 stack interface that stack-using engines and scripted test fixtures drive. It adds occupancy tracking, full/empty status and sticky overflow/underflow error flags. It sits beside the evaluator datapath as a data or return stack and runs on the system clock.

---
 rtl/lifo_stack.sv | 130 +++++++++++++
 tb/tb_lifo_stack.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_stack.sv
// lifo_stack: register-file LIFO that presents its top two entries.
// Push, pop and replace are single-cycle strobes; occupancy and full/empty
// status are tracked, and overflow/underflow are reported as sticky flags.
// Optional feature macro: LIFO_STACK_HWM_EN adds the o_hwm high-water mark.
module lifo_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clr_err,
    output logic [WIDTH-1:0]           o_s0,
    output logic [WIDTH-1:0]           o_s1,
    output logic [$clog2(DEPTH+1)-1:0] o_depth,
    output logic                       o_empty,
    output logic                       o_full,
    output logic                       o_overflow,
`ifdef LIFO_STACK_HWM_EN
    output logic                       o_underflow,
    output logic [$clog2(DEPTH+1)-1:0] o_hwm
`else
    output logic                       o_underflow
`endif
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] LP_DEPTH = DW'(DEPTH);

    logic [WIDTH-1:0] r_entry [DEPTH];
    logic [DW-1:0]    r_depth;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_empty;
    logic             w_full;
    logic             w_doPush;
    logic             w_doPop;
    logic             w_doReplace;
    logic             w_ovfEvent;
    logic             w_unfEvent;
    logic [DW-1:0]    w_depthNext;

    // Decode the request strobes against the current occupancy.
    always_comb begin
        w_empty     = (r_depth == '0);
        w_full      = (r_depth == LP_DEPTH);
        w_doPush    = i_push & ~i_pop & ~w_full;
        w_doPop     = ~i_push & i_pop & ~w_empty;
        w_doReplace = i_push & i_pop & ~w_empty;
        w_ovfEvent  = i_push & ~i_pop & w_full;
        // Both pop and replace need a top entry to act on.
        w_unfEvent  = i_pop & w_empty;
        w_depthNext = r_depth;
        if (w_doPush) begin
            w_depthNext = r_depth + DW'(1);
        end else if (w_doPop) begin
            w_depthNext = r_depth - DW'(1);
        end
    end

    // Entry storage: shift down on push, shift up on pop, rewrite top on replace.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
        end else if (w_doPush) begin
            for (int i = 1; i < DEPTH; i++) begin
                r_entry[i] <= r_entry[i-1];
            end
            r_entry[0] <= i_data;
        end else if (w_doPop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                r_entry[i] <= r_entry[i+1];
            end
            r_entry[DEPTH-1] <= '0;
        end else if (w_doReplace) begin
            r_entry[0] <= i_data;
        end
    end

    // Occupancy counter; the decode above keeps it within 0..DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_depth <= '0;
        end else begin
            r_depth <= w_depthNext;
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_ovfEvent | (r_overflow & ~i_clr_err);
            r_underflow <= w_unfEvent | (r_underflow & ~i_clr_err);
        end
    end

`ifdef LIFO_STACK_HWM_EN
    logic [DW-1:0] r_hwm;

    // High-water mark follows the new depth; clearing errors rebases it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hwm <= '0;
        end else if (i_clr_err) begin
            r_hwm <= w_depthNext;
        end else if (w_depthNext > r_hwm) begin
            r_hwm <= w_depthNext;
        end
    end

    assign o_hwm = r_hwm;
`endif

    assign o_s0        = r_entry[0];
    assign o_s1        = r_entry[1];
    assign o_depth     = r_depth;
    assign o_empty     = w_empty;
    assign o_full      = w_full;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed vector table, hand-written reset/HWM sequences and
// randomized traffic checked against a queue-based stack model.
module tb_lifo_stack;

    logic       i_clk;
    logic       i_rst_n;
    logic [7:0] i_data;
    logic       i_push;
    logic       i_pop;
    logic       i_clr_err;
    logic [7:0] o_s0;
    logic [7:0] o_s1;
    logic [3:0] o_depth;
    logic       o_empty;
    logic       o_full;
    logic       o_overflow;
    logic       o_underflow;
`ifdef LIFO_STACK_HWM_EN
    logic [3:0] o_hwm;
`endif

    lifo_stack #(.WIDTH(8), .DEPTH(8)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_data      (i_data),
        .i_push      (i_push),
        .i_pop       (i_pop),
        .i_clr_err   (i_clr_err),
        .o_s0        (o_s0),
        .o_s1        (o_s1),
        .o_depth     (o_depth),
        .o_empty     (o_empty),
        .o_full      (o_full),
        .o_overflow  (o_overflow),
`ifdef LIFO_STACK_HWM_EN
        .o_underflow (o_underflow),
        .o_hwm       (o_hwm)
`else
        .o_underflow (o_underflow)
`endif
    );

    typedef struct {
        logic       push;
        logic       pop;
        logic       clr;
        logic [7:0] data;
        logic [7:0] s0;
        logic [7:0] s1;
        logic [3:0] depth;
        logic       empty;
        logic       full;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t       vecs[$];
    int         checks = 0;
    int         errors = 0;

    // Behavioural model: index 0 of the queue is the top of stack.
    logic [7:0] mStack[$];
    logic       mOvf = 1'b0;
    logic       mUnf = 1'b0;
    int         mHwm = 0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic void addVec(input logic push, input logic pop, input logic clr,
                                   input logic [7:0] data, input logic [7:0] s0,
                                   input logic [7:0] s1, input logic [3:0] depth,
                                   input logic ovf, input logic unf);
        vec_t v;
        v.push  = push;
        v.pop   = pop;
        v.clr   = clr;
        v.data  = data;
        v.s0    = s0;
        v.s1    = s1;
        v.depth = depth;
        v.empty = (depth == 4'd0);
        v.full  = (depth == 4'd8);
        v.ovf   = ovf;
        v.unf   = unf;
        vecs.push_back(v);
    endfunction

    function automatic void modelReset();
        mStack.delete();
        mOvf = 1'b0;
        mUnf = 1'b0;
        mHwm = 0;
    endfunction

    function automatic void modelStep(input logic push, input logic pop, input logic clr,
                                      input logic [7:0] data);
        logic ovfEvt;
        logic unfEvt;
        ovfEvt = 1'b0;
        unfEvt = 1'b0;
        if (push && !pop) begin
            if (mStack.size() == 8) ovfEvt = 1'b1;
            else mStack.push_front(data);
        end else if (pop && !push) begin
            if (mStack.size() == 0) unfEvt = 1'b1;
            else void'(mStack.pop_front());
        end else if (push && pop) begin
            if (mStack.size() == 0) unfEvt = 1'b1;
            else mStack[0] = data;
        end
        mOvf = ovfEvt | (mOvf & !clr);
        mUnf = unfEvt | (mUnf & !clr);
        if (clr) mHwm = mStack.size();
        else if (mStack.size() > mHwm) mHwm = mStack.size();
    endfunction

    function automatic logic [7:0] modelAt(input int idx);
        return (mStack.size() > idx) ? mStack[idx] : 8'h00;
    endfunction

    task automatic checkOne(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                               input logic [3:0] depth, input logic empty, input logic full,
                               input logic ovf, input logic unf);
        checkOne({tag, ".s0"}, o_s0, s0);
        checkOne({tag, ".s1"}, o_s1, s1);
        checkOne({tag, ".depth"}, {4'd0, o_depth}, {4'd0, depth});
        checkOne({tag, ".empty"}, {7'd0, o_empty}, {7'd0, empty});
        checkOne({tag, ".full"}, {7'd0, o_full}, {7'd0, full});
        checkOne({tag, ".overflow"}, {7'd0, o_overflow}, {7'd0, ovf});
        checkOne({tag, ".underflow"}, {7'd0, o_underflow}, {7'd0, unf});
    endtask

    task automatic checkModel(input string tag);
        checkOutput(tag, modelAt(0), modelAt(1), 4'(mStack.size()),
                    mStack.size() == 0, mStack.size() == 8, mOvf, mUnf);
`ifdef LIFO_STACK_HWM_EN
        checkOne({tag, ".hwm"}, {4'd0, o_hwm}, 8'(mHwm));
`endif
    endtask

    // Drive one operation for one clock, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic push, input logic pop, input logic clr,
                                 input logic [7:0] data);
        i_push    = push;
        i_pop     = pop;
        i_clr_err = clr;
        i_data    = data;
        @(posedge i_clk);
        #1;
        modelStep(push, pop, clr, data);
        i_push    = 1'b0;
        i_pop     = 1'b0;
        i_clr_err = 1'b0;
    endtask

    task automatic doReset();
        i_rst_n = 1'b0;
        #12;
        modelReset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        i_push    = 1'b0;
        i_pop     = 1'b0;
        i_clr_err = 1'b0;
        i_data    = 8'h00;
        doReset();
        checkOutput("reset", 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Directed table: push/pop, replace, overflow, underflow.
        addVec(1, 0, 0, 8'hD5, 8'hD5, 8'h00, 1, 0, 0);
        addVec(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        addVec(1, 0, 0, 8'h11, 8'h11, 8'h00, 1, 0, 0);
        addVec(1, 0, 0, 8'h22, 8'h22, 8'h11, 2, 0, 0);
        addVec(1, 1, 0, 8'h33, 8'h33, 8'h11, 2, 0, 0);
        addVec(0, 1, 0, 8'h00, 8'h11, 8'h00, 1, 0, 0);
        addVec(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        for (int k = 1; k <= 8; k++)
            addVec(1, 0, 0, 8'(k), 8'(k), 8'(k - 1), 4'(k), 0, 0);
        addVec(1, 0, 0, 8'h09, 8'h08, 8'h07, 8, 1, 0);
        addVec(0, 1, 0, 8'h00, 8'h07, 8'h06, 7, 1, 0);
        addVec(0, 0, 1, 8'h00, 8'h07, 8'h06, 7, 0, 0);
        for (int k = 6; k >= 0; k--)
            addVec(0, 1, 0, 8'h00, 8'(k), (k > 0) ? 8'(k - 1) : 8'h00, 4'(k), 0, 0);
        addVec(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1);
        addVec(1, 1, 0, 8'hAA, 8'h00, 8'h00, 0, 0, 1);
        addVec(0, 1, 1, 8'h00, 8'h00, 8'h00, 0, 0, 1);
        addVec(0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].data);
            checkOutput($sformatf("vec%0d", i), vecs[i].s0, vecs[i].s1, vecs[i].depth,
                        vecs[i].empty, vecs[i].full, vecs[i].ovf, vecs[i].unf);
        end

        // Asynchronous reset between clock edges clears contents and flags at once.
        applyStimulus(0, 1, 0, 8'h00);
        applyStimulus(1, 0, 0, 8'hBE);
        applyStimulus(1, 0, 0, 8'hEF);
        checkOutput("prerst", 8'hEF, 8'hBE, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        i_rst_n = 1'b0;
        #1;
        checkOutput("asyncrst", 8'h00, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        modelReset();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        applyStimulus(1, 0, 0, 8'h5A);
        checkOutput("postrst", 8'h5A, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef LIFO_STACK_HWM_EN
        doReset();
        for (int k = 0; k < 5; k++) applyStimulus(1, 0, 0, 8'(8'h40 + k));
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 8'h00);
        checkOne("hwm.peak", {4'd0, o_hwm}, 8'd5);
        checkOne("hwm.depth", {4'd0, o_depth}, 8'd2);
        applyStimulus(0, 0, 1, 8'h00);
        checkOne("hwm.clr", {4'd0, o_hwm}, 8'd2);
        applyStimulus(1, 0, 0, 8'h77);
        checkOne("hwm.push", {4'd0, o_hwm}, 8'd3);
`endif

        // Randomized traffic against the queue model, biased to reach both ends.
        doReset();
        for (int n = 0; n < 400; n++) begin
            int    sel;
            logic  p;
            logic  q;
            sel = $urandom_range(0, 9);
            p   = (sel < 4) || (sel == 8);
            q   = ((sel >= 4) && (sel < 8)) || (sel == 8);
            if (n >= 200) begin
                p = (sel < 6) || (sel == 9);
                q = (sel >= 6);
            end
            applyStimulus(p, q, ($urandom_range(0, 7) == 0), 8'($urandom));
            checkModel($sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
